// File: rtl/c3lib_fifo_pkg.sv
// Shared types for the c3lib FIFO read-side streaming logic.
package c3lib_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/c3lib_skid_buf2.sv
// Two-entry in-order output buffer; entry 0 is always the oldest word.
module c3lib_skid_buf2 #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic [1:0]        count
);

  logic [DWIDTH-1:0] e0, e1;
  logic [1:0]        cnt;
  logic              do_pop, do_push;

  assign do_pop  = pop & (cnt != 2'd0);
  assign do_push = push & ((cnt != 2'd2) | do_pop);
  assign dout    = e0;
  assign count   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        // Simultaneous push/pop: count holds, order preserved by shifting.
        2'b11: begin
          if (cnt == 2'd1) e0 <= din;
          else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/c3lib_fifo_rd_stream.sv
// Streams words out of a show-ahead FIFO once a start threshold is met.
// Optional: define C3LIB_FIFO_RD_STREAM_UFLOW_CNT_EN for a saturating underflow counter.
module c3lib_fifo_rd_stream
  import c3lib_fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [AWIDTH-1:0] r_start_thresh,
  input  logic              r_refill_en,
  input  logic [DWIDTH-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  input  logic [AWIDTH-1:0] fifo_numdata,
  output logic              fifo_rd_en,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        state,
  output logic              underflow,
  output logic [15:0]       uflow_cnt
);

  rd_state_e  st, st_nxt;
  logic [1:0] cnt;
  logic       uflow_evt;

  // Pop decision uses only registered buffer occupancy, never out_ready.
  assign fifo_rd_en = (st == ST_RUN) & ~fifo_empty & (cnt != 2'd2) & ~flush;
  assign uflow_evt  = (st == ST_RUN) & (cnt == 2'd0) & fifo_empty;
  assign out_valid  = (cnt != 2'd0);
  assign state      = st;

  c3lib_skid_buf2 #(.DWIDTH(DWIDTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (fifo_rd_en),
    .pop   (out_valid & out_ready),
    .din   (fifo_rd_data),
    .dout  (out_data),
    .count (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (flush) st_nxt = ST_IDLE;
    else begin
      case (st)
        ST_IDLE:  if (enable) st_nxt = ST_FILL;
        ST_FILL: begin
          if (!enable) st_nxt = ST_IDLE;
          else if (!fifo_empty && (fifo_numdata >= r_start_thresh)) st_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!enable) st_nxt = ST_DRAIN;
          else if (uflow_evt && r_refill_en) st_nxt = ST_FILL;
        end
        ST_DRAIN: if (cnt == 2'd0) st_nxt = ST_IDLE;
        default:  st_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         underflow <= 1'b0;
    else if (uflow_evt) underflow <= 1'b1;
  end

`ifdef C3LIB_FIFO_RD_STREAM_UFLOW_CNT_EN
  logic [15:0] uflow_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         uflow_q <= 16'd0;
    else if (uflow_evt) uflow_q <= sat_inc16(uflow_q);
  end
  assign uflow_cnt = uflow_q;
`else
  assign uflow_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_c3lib_fifo_rd_stream.sv
// Directed bench for c3lib_fifo_rd_stream: FIFO model + expected-word scoreboard.
module tb_c3lib_fifo_rd_stream;
  localparam int DW = 8;
  localparam int AW = 4;
`ifdef C3LIB_FIFO_RD_STREAM_UFLOW_CNT_EN
  localparam logic [15:0] UF1 = 16'd1;
`else
  localparam logic [15:0] UF1 = 16'd0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          enable = 1'b0, flush = 1'b0, r_refill_en = 1'b1, out_ready = 1'b1;
  logic [AW-1:0] r_start_thresh = 4'd4;
  logic [AW-1:0] fifo_numdata = '0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en, out_valid, underflow;
  logic [DW-1:0] out_data;
  logic [1:0]    state;
  logic [15:0]   uflow_cnt;

  int total = 0, bad = 0, pop_cnt = 0, pc = 0, seen = -1;

  c3lib_fifo_rd_stream #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .r_start_thresh(r_start_thresh), .r_refill_en(r_refill_en),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_numdata(fifo_numdata),
    .fifo_rd_en(fifo_rd_en), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .state(state), .underflow(underflow), .uflow_cnt(uflow_cnt)
  );

  always #5 clk = ~clk;

  // Upstream show-ahead FIFO model
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic          push_v = 1'b0, fifo_clr = 1'b0;
  logic [DW-1:0] push_d = '0;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fq.size() > 0) begin
        void'(fq.pop_front());
        pop_cnt++;
      end else begin
        total++; bad++;
        $display("FAIL fifo_pop_empty got=rd_en exp=no_pop");
      end
    end
    if (fifo_clr) fq.delete();
    if (push_v) fq.push_back(push_d);
    fifo_empty   <= (fq.size() == 0);
    fifo_numdata <= AW'(fq.size());
    fifo_rd_data <= (fq.size() > 0) ? fq[0] : '0;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_word got=%0h exp=none", out_data);
      end else begin
        chk("stream_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input bit keep);
    push_v = 1'b1;
    push_d = d;
    if (keep) exp_q.push_back(d);
    tick();
    push_v = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("rst_state", state, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_uflow", underflow, 0);
    chk("rst_uflow_cnt", uflow_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Start threshold and in-order streaming
    enable = 1'b1;
    tick();
    chk("idle_to_fill", state, 1);
    for (int i = 0; i < 8; i++) begin
      push_word(DW'(i + 1), 1'b1);
      if (seen < 0 && fifo_numdata >= 4) begin
        seen = i;
        chk("rd_en_pre_thresh", fifo_rd_en, 0);
      end else if (seen >= 0 && i == seen + 1) begin
        chk("rd_en_first", fifo_rd_en, 1);
      end
    end
    chk("thresh_seen", seen, 3);
    for (int k = 0; k < 40 && state != 2'd1; k++) tick();
    chk("refill_state", state, 1);
    chk("underflow_set", underflow, 1);
    chk("uflow_cnt_one", uflow_cnt, UF1);
    chk("t1_all_delivered", exp_q.size(), 0);

    // Backpressure: buffer fills, pop stops, then back-to-back delivery
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(DW'(8'h11 + i), 1'b1);
    repeat (5) tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_rd_en", fifo_rd_en, 0);
    chk("bp_fifo_left", fifo_numdata, 4);
    chk("bp_state", state, 2);
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("b2b_valid", out_valid, 1);
      tick();
    end
    chk("b2b_end", out_valid, 0);
    for (int k = 0; k < 10 && state != 2'd1; k++) tick();
    chk("refill_again", state, 1);

    // No refill: underflow keeps RUN
    r_refill_en = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(8'h21 + i), 1'b1);
    for (int k = 0; k < 40 && (exp_q.size() != 0 || out_valid); k++) tick();
    repeat (3) tick();
    chk("norefill_run", state, 2);
    chk("norefill_uflow", underflow, 1);

    // Drain: two buffered words delivered, FIFO left untouched
    out_ready = 1'b0;
    push_word(8'h31, 1'b1);
    push_word(8'h32, 1'b1);
    push_word(8'h33, 1'b0);
    push_word(8'h34, 1'b0);
    repeat (2) tick();
    chk("drain_pre_fifo", fifo_numdata, 2);
    chk("drain_pre_valid", out_valid, 1);
    pc = pop_cnt;
    enable = 1'b0;
    tick();
    chk("drain_state", state, 3);
    chk("drain_rd_en", fifo_rd_en, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && state != 2'd0; k++) tick();
    chk("drain_idle", state, 0);
    chk("drain_no_pop", pop_cnt - pc, 0);
    chk("drain_fifo_left", fifo_numdata, 2);
    chk("drain_delivered", exp_q.size(), 0);

    // Flush with two words buffered (threshold 0)
    out_ready = 1'b0;
    r_start_thresh = 4'd0;
    push_word(8'h35, 1'b0);
    enable = 1'b1;
    for (int k = 0; k < 20 && !(out_valid && fifo_numdata == 1 && !fifo_rd_en && state == 2'd2); k++) tick();
    chk("flush_setup", fifo_numdata, 1);
    pc = pop_cnt;
    flush = 1'b1;
    enable = 1'b0;
    #1;
    chk("flush_rd_en", fifo_rd_en, 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_state", state, 0);
    chk("flush_no_pop", pop_cnt - pc, 0);
    chk("flush_fifo_left", fifo_numdata, 1);
    chk("flush_keeps_uflow", underflow, 1);

    // Reset mid-stream with two words buffered
    enable = 1'b1;
    push_word(8'h36, 1'b0);
    push_word(8'h37, 1'b0);
    for (int k = 0; k < 20 && !(out_valid && fifo_numdata == 1 && !fifo_rd_en && state == 2'd2); k++) tick();
    chk("rstm_setup", fifo_numdata, 1);
    tick();
    pc = pop_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstm_valid", out_valid, 0);
    chk("rstm_state", state, 0);
    chk("rstm_rd_en", fifo_rd_en, 0);
    chk("rstm_data", out_data, 0);
    chk("rstm_uflow", underflow, 0);
    enable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rstm_no_pop", pop_cnt - pc, 0);
    chk("rstm_fifo_left", fifo_numdata, 1);

    // Threshold 0 still waits for a non-empty FIFO
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
    enable = 1'b1;
    repeat (4) tick();
    chk("thr0_empty_fill", state, 1);
    out_ready = 1'b1;
    push_word(8'h41, 1'b1);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    tick();
    chk("thr0_delivered", exp_q.size(), 0);
    chk("thr0_run", state, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
